// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state encoding and a
// log2 width helper used to size the requester index fields.
package shared_reg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'b00;
    localparam state_t GRANT = 2'b01;
    localparam state_t ACK   = 2'b10;

    // Smallest r with 2**r >= n; elaboration-time helper only.
    function automatic int log2w(input int n);
        int r;
        r = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 32'sd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches req from ptr+1 upward with
// wrap-around and returns the one-hot winner and its index.
module rr_pick
    import shared_reg_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = log2w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    logic [PW-1:0] cand_s;

    // Farthest candidate first so the nearest requesting one is written last and wins.
    always_comb begin
        onehot = {NREQ{1'b0}};
        idx    = {PW{1'b0}};
        valid  = 1'b0;
        cand_s = ptr;
        for (int i = NREQ; i >= 1; i--) begin
            cand_s = ptr + PW'(i);
            if (req[cand_s]) begin
                idx   = cand_s;
                valid = 1'b1;
            end else begin
                idx   = idx;
                valid = valid;
            end
        end
        onehot[idx] = valid;
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Optional grant locking (Lock port, MAXLOCK burst limit) with SHARED_REG_LOCK_EN.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
`ifdef SHARED_REG_LOCK_EN
    ,
    parameter int MAXLOCK = 4
`endif
) (
    input  logic                     Clk,
    input  logic                     Resetn,
    input  logic [NREQ-1:0]          Req,
    input  logic [NREQ*WIDTH-1:0]    WrData,
`ifdef SHARED_REG_LOCK_EN
    input  logic [NREQ-1:0]          Lock,
`endif
    output logic [NREQ-1:0]          Gnt,
    output logic [NREQ-1:0]          Ack,
    output logic [WIDTH-1:0]         Q,
    output logic [log2w(NREQ)-1:0]   Owner,
    output logic                     Busy
);

    localparam int PW = log2w(NREQ);
`ifdef SHARED_REG_LOCK_EN
    localparam int CW = log2w(MAXLOCK) + 1;
    logic [CW-1:0]    cnt_r;
`endif

    state_t           state_r;
    logic [NREQ-1:0]  gnt_r;
    logic [NREQ-1:0]  ack_r;
    logic [WIDTH-1:0] q_r;
    logic [PW-1:0]    owner_r;
    logic             busy_r;
    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    win_r;

    logic [NREQ-1:0]  pick_onehot_s;
    logic [PW-1:0]    pick_idx_s;
    logic             pick_valid_s;
    logic [NREQ-1:0]  win_onehot_s;
    logic [WIDTH-1:0] win_data_s;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req    (Req),
        .ptr    (ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // Decode the latched winner; only its request and data lanes are ever sampled.
    always_comb begin
        win_onehot_s        = {NREQ{1'b0}};
        win_onehot_s[win_r] = 1'b1;
        win_data_s          = WrData[int'(win_r)*WIDTH +: WIDTH];
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= IDLE;
            gnt_r   <= {NREQ{1'b0}};
            ack_r   <= {NREQ{1'b0}};
            q_r     <= {WIDTH{1'b0}};
            owner_r <= {PW{1'b0}};
            busy_r  <= 1'b0;
            ptr_r   <= PW'(NREQ - 1);
            win_r   <= {PW{1'b0}};
`ifdef SHARED_REG_LOCK_EN
            cnt_r   <= {CW{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        gnt_r   <= pick_onehot_s;
                        win_r   <= pick_idx_s;
                        busy_r  <= 1'b1;
                        state_r <= GRANT;
                    end
                end
                GRANT: begin
                    gnt_r <= {NREQ{1'b0}};
                    if (Req[win_r]) begin
                        q_r     <= win_data_s;
                        owner_r <= win_r;
                        ack_r   <= win_onehot_s;
                        ptr_r   <= win_r;
                        state_r <= ACK;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
`ifdef SHARED_REG_LOCK_EN
                        cnt_r   <= {CW{1'b0}};
`endif
                    end
                end
                ACK: begin
                    ack_r <= {NREQ{1'b0}};
`ifdef SHARED_REG_LOCK_EN
                    // Locked burst: regrant the same winner until MAXLOCK writes are done.
                    if (Lock[win_r] && Req[win_r] && (cnt_r < CW'(MAXLOCK - 1))) begin
                        gnt_r   <= win_onehot_s;
                        cnt_r   <= cnt_r + CW'(1'b1);
                        state_r <= GRANT;
                    end else begin
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
`else
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
`endif
                end
                default: begin
                    gnt_r   <= {NREQ{1'b0}};
                    ack_r   <= {NREQ{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign Gnt   = gnt_r;
    assign Ack   = ack_r;
    assign Q     = q_r;
    assign Owner = owner_r;
    assign Busy  = busy_r;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: transaction-level model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_shared_reg_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
`ifdef SHARED_REG_LOCK_EN
    localparam int MAXLOCK = 4;
`endif

    logic        clk     = 1'b0;
    logic        resetn  = 1'b1;
    logic [3:0]  req     = 4'b0000;
    logic [31:0] wr_data = 32'h0;
`ifdef SHARED_REG_LOCK_EN
    logic [3:0]  lock    = 4'b0000;
`endif
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shared_reg_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
`ifdef SHARED_REG_LOCK_EN
        ,
        .MAXLOCK (MAXLOCK)
`endif
    ) dut (
        .Clk    (clk),
        .Resetn (resetn),
        .Req    (req),
        .WrData (wr_data),
`ifdef SHARED_REG_LOCK_EN
        .Lock   (lock),
`endif
        .Gnt    (gnt),
        .Ack    (ack),
        .Q      (q),
        .Owner  (owner),
        .Busy   (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot_of(input int w);
        logic [3:0] v;
        v = 4'b0000;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Next requester after p in circular order, -1 if nobody asks.
    function automatic int rr_next(input int p, input logic [3:0] r);
        for (int i = 1; i <= NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    // Model: who currently holds a grant, who is being acknowledged, and the register.
    int         m_gnt = -1;
    int         m_ack = -1;
    int         m_ptr = NREQ - 1;
    int         m_owner = 0;
    int         m_cnt = 0;
    logic [7:0] m_q = 8'h00;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_gnt <= -1; m_ack <= -1; m_ptr <= NREQ - 1;
            m_owner <= 0; m_q <= 8'h00; m_cnt <= 0;
        end else if (m_gnt >= 0) begin
            m_gnt <= -1;
            if (req[m_gnt]) begin
                m_q     <= wr_data[m_gnt*WIDTH +: WIDTH];
                m_owner <= m_gnt;
                m_ptr   <= m_gnt;
                m_ack   <= m_gnt;
            end else begin
                m_cnt   <= 0;
            end
        end else if (m_ack >= 0) begin
            m_ack <= -1;
`ifdef SHARED_REG_LOCK_EN
            if (lock[m_ack] && req[m_ack] && m_cnt < MAXLOCK - 1) begin
                m_gnt <= m_ack;
                m_cnt <= m_cnt + 1;
            end else begin
                m_cnt <= 0;
            end
`endif
        end else begin
            m_gnt <= rr_next(m_ptr, req);
        end
    end

    always @(negedge clk) begin
        chk("gnt", {28'h0, gnt}, {28'h0, onehot_of(m_gnt)});
        chk("ack", {28'h0, ack}, {28'h0, onehot_of(m_ack)});
        chk("q", {24'h0, q}, {24'h0, m_q});
        chk("owner", {30'h0, owner}, m_owner);
        chk("busy", {31'h0, busy}, {31'h0, (m_gnt >= 0) || (m_ack >= 0)});
        chk("gnt_ack_excl", {28'h0, gnt & ack}, 32'h0);
    end

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int         gq[$];
    logic [7:0] qq[$];
    int         aq[$];
    int         ac[$];
    int         ack_seen;
    int         exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        #1 resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        step(1);
        chk("rst_q", {24'h0, q}, 32'h0);
        chk("rst_gnt", {28'h0, gnt}, 32'h0);
        chk("rst_ack", {28'h0, ack}, 32'h0);
        chk("rst_owner", {30'h0, owner}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);

        // Contention: every requester writes its own index.
        wr_data = 32'h03020100;
        req = 4'b1111;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (gnt != 4'b0000) gq.push_back(idx_of(gnt));
            if (ack != 4'b0000) qq.push_back(q);
        end
        req = 4'b0000;
        step(3);
        chk("cont_ngrant", gq.size(), 32'd5);
        chk("cont_nack", qq.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("cont_order", (i < gq.size()) ? gq[i] : 99, exp_order[i]);
            chk("cont_qseq", (i < qq.size()) ? {24'h0, qq[i]} : 32'hff, exp_order[i]);
        end

        // Single request from requester 2.
        wr_data = 32'h00A50000;
        req = 4'b0100;
        step(1);
        chk("single_gnt", {28'h0, gnt}, 32'h4);
        chk("single_noack", {28'h0, ack}, 32'h0);
        step(1);
        chk("single_q", {24'h0, q}, 32'hA5);
        chk("single_ack", {28'h0, ack}, 32'h4);
        chk("single_owner", {30'h0, owner}, 32'd2);
        req = 4'b0000;
        step(1);
        chk("single_ack_clr", {28'h0, ack}, 32'h0);
        chk("single_idle", {31'h0, busy}, 32'h0);

        // Abort: requester 1 drops its request while granted.
        wr_data = 32'h00001100;
        req = 4'b0010;
        step(1);
        chk("abort_gnt", {28'h0, gnt}, 32'h2);
        req = 4'b0000;
        step(1);
        chk("abort_noack", {28'h0, ack}, 32'h0);
        chk("abort_idle", {31'h0, busy}, 32'h0);
        chk("abort_q", {24'h0, q}, 32'hA5);
        chk("abort_owner", {30'h0, owner}, 32'd2);
        step(1);
        chk("abort_late_ack", {28'h0, ack}, 32'h0);
        // ptr still 2, so requester 0 beats requester 2.
        wr_data = 32'h00CC003C;
        req = 4'b0101;
        step(1);
        chk("abort_ptr_gnt", {28'h0, gnt}, 32'h1);
        step(1);
        chk("abort_ptr_q", {24'h0, q}, 32'h3C);
        chk("abort_ptr_ack", {28'h0, ack}, 32'h1);
        req = 4'b0000;
        step(2);

        // Reset while requester 3 is granted.
        wr_data = 32'h77000000;
        req = 4'b1000;
        step(1);
        chk("rstg_gnt", {28'h0, gnt}, 32'h8);
        #2 resetn = 1'b0;
        #1;
        chk("rstg_gnt_clr", {28'h0, gnt}, 32'h0);
        chk("rstg_q", {24'h0, q}, 32'h0);
        chk("rstg_busy", {31'h0, busy}, 32'h0);
        req = 4'b0000;
        ack_seen = 0;
        step(1);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (ack != 4'b0000) ack_seen++;
        end
        chk("rstg_no_ack", ack_seen, 32'd0);
        chk("rstg_q_after", {24'h0, q}, 32'h0);

`ifdef SHARED_REG_LOCK_EN
        // Move ptr to 2 so requester 3 wins over requester 0.
        wr_data = 32'h5A22000F;
        req = 4'b0100;
        step(2);
        req = 4'b0000;
        step(2);
        req = 4'b1001;
        lock = 4'b1000;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (ack != 4'b0000) begin
                aq.push_back(idx_of(ack));
                ac.push_back(i);
            end
        end
        req = 4'b0000;
        lock = 4'b0000;
        step(3);
        chk("lock_nack", aq.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("lock_who", (i < aq.size()) ? aq[i] : 99, (i < 4) ? 3 : 0);
            chk("lock_when", (i < ac.size()) ? ac[i] : 99, (i < 4) ? 2 + 2 * i : 11);
        end
        chk("lock_q", {24'h0, q}, 32'h0F);
        chk("lock_owner", {30'h0, owner}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter and write sequencer for one shared WIDTH-bit storage register built from edge-triggered D flip-flops. Up to NREQ requesters (board switches, keys or other lab blocks) compete to load the register; the block grants one at a time, commits its data, and acknowledges. It sits between the requester logic and the shared register, and it drives the register contents to LEDR/HEX outputs at top level.

## Interface
- WIDTH, 8: shared register width in bits.
- NREQ, 4: number of requesters; power of two, at least 2.
- MAXLOCK, 4: maximum consecutive locked writes; used only with SHARED_REG_LOCK_EN.

- Clk  in  1  single clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Req  in  NREQ  per-requester write request; level, held until Ack or abandoned.
- WrData  in  NREQ*WIDTH  flattened data; requester i uses bits [i*WIDTH +: WIDTH].
- Lock  in  NREQ  per-requester hold-grant request; port exists only with SHARED_REG_LOCK_EN.
- Gnt  out  NREQ  one-hot grant, registered.
- Ack  out  NREQ  one-hot, one-cycle pulse; write committed.
- Q  out  WIDTH  shared register contents.
- Owner  out  log2(NREQ)  index of the last requester that wrote Q.
- Busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, GRANT, ACK.
- IDLE: if any Req bit is high, select the winner with the round-robin picker, searching from ptr+1 upward with wrap. Set Gnt for the winner, record the winner index, then go to GRANT. If no Req bit is high, stay in IDLE.
- GRANT, winner's Req still high:
  - Load Q with WrData of the winner.
  - Load Owner with the winner index.
  - Clear Gnt, pulse the winner's Ack bit, set ptr to the winner, go to ACK.
- GRANT, winner's Req low (abort):
  - Clear Gnt, go to IDLE.
  - Q, Owner, ptr and Ack are unchanged.
- ACK: clear Ack, go to IDLE.
- Only the granted requester's Req and WrData are sampled. Req changes from other requesters during GRANT or ACK have no effect until the next IDLE.
- Fairness: a requester that holds Req continuously is granted within NREQ arbitration rounds.
- Reset values:
  - Gnt=0, Ack=0, Q=0, Owner=0, Busy=0, state=IDLE.
  - ptr=NREQ-1, so requester 0 has first priority.
- Reset mid-operation: Resetn low in any state forces all reset values asynchronously. A write in flight is dropped, and no Ack is issued.

## Timing
- Req first sampled high at edge k in IDLE:
  - Gnt high during cycle k+1.
  - Q updated and Ack high during cycle k+2.
  - IDLE during cycle k+3.
- Unlocked throughput: one write per 3 cycles. The earliest next Gnt for a request pending at edge k+3 is cycle k+4.
- Gnt and Ack are never high in the same cycle.
- Busy is high exactly in cycles k+1 and k+2.

## Configuration
- SHARED_REG_LOCK_EN defined:
  - Lock port present; a lock counter of log2(MAXLOCK)+1 bits is added.
  - In ACK, if Lock[winner] and Req[winner] are both high and the counter is below MAXLOCK-1, return directly to GRANT for the same winner. ptr is held and the counter increments, giving one write per 2 cycles.
  - Otherwise go to IDLE and clear the counter; at MAXLOCK writes the grant is forcibly released.
  - The counter is cleared on reset and on abort.
- SHARED_REG_LOCK_EN undefined: no Lock port and no counter; behaviour is exactly as in Operation.

## Structure
- Package shared_reg_pkg holds:
  - State encoding localparams: IDLE=2'b00, GRANT=2'b01, ACK=2'b10.
  - The log2 width helper function used for Owner and ptr.
- Sub-module rr_pick, combinational:
  - Inputs: Req and ptr.
  - Outputs: a one-hot winner and its index, searching from ptr+1 with wrap-around.
  - Instantiated once inside shared_reg_arbiter.

## Test plan
All scenarios use WIDTH=8, NREQ=4.
- Reset: Resetn low, then high → Q=8'h00, Gnt=0, Ack=0, Owner=0, Busy=0.
- Single request: Req=4'b0100, WrData[2]=8'hA5 → Gnt=4'b0100 in the next cycle; the cycle after, Q=8'hA5, Ack=4'b0100 for one cycle, Owner=2.
- Contention: Req=4'b1111 held; each requester's WrData equals its index → grant order 0,1,2,3,0, 3 cycles per grant; Q follows 00,01,02,03,00.
- Abort: requester 1 drops Req while Gnt=4'b0010 → no Ack, Q unchanged, IDLE next cycle, ptr unchanged.
- Reset in GRANT: Resetn pulsed low while Gnt=4'b1000 → Gnt clears immediately, Q=0, no Ack ever issued.
- SHARED_REG_LOCK_EN built, MAXLOCK=4: Req and Lock held for requester 3, Req also held for requester 0 → four Acks to requester 3 spaced 2 cycles apart, then a forced release; the next grant goes to requester 0.
